// File: rtl/dwconv3x3_stream.sv
// Streaming depthwise 3x3 convolution: CHANNELS lanes, two line buffers, stride 1/2, same/valid padding.
// Latency: out_valid rises 3 clock edges after the edge accepting the pixel that completes a window.
// Backpressure: one global advance (!out_valid || out_ready) freezes every stage; in_ready is gated by it.
module dwconv3x3_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int CHANNELS   = 4,
    parameter int MAX_DIM    = 224,
    parameter int DIM_WIDTH  = 8,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              start,
    input  logic [DIM_WIDTH-1:0]              cfg_dim,
    input  logic                              cfg_stride,
    input  logic                              cfg_pad,
    input  logic [CHANNELS*9*DATA_WIDTH-1:0]  weights,
    input  logic [CHANNELS*ACC_WIDTH-1:0]     biases,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [CHANNELS*DATA_WIDTH-1:0]    in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [CHANNELS*ACC_WIDTH-1:0]     out_data,
    output logic                              out_last,
    output logic                              busy,
    output logic                              done
);

    localparam int CW    = DIM_WIDTH + 1;
    localparam int PW    = CHANNELS * DATA_WIDTH;
    localparam int MW    = 2 * DATA_WIDTH + 1;
    localparam int LB_AW = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] ONE   = CW'(1);
    localparam logic [CW-1:0] TWO   = CW'(2);
    localparam logic [CW-1:0] THREE = CW'(3);

    generate
        if (ACC_WIDTH < 2 * DATA_WIDTH + 5) begin : g_acc_width_check
            $error("ACC_WIDTH must be at least 2*DATA_WIDTH+5");
        end
    endgenerate

    // control and scan state
    logic [1:0]    state;
    logic [CW-1:0] dim_q;
    logic          stride_q;
    logic          pad_q;
    logic [CW-1:0] y;
    logic [CW-1:0] x;
    logic          scan_done;
    logic          last_sent;

    // line buffers: lb_m1 holds the previous row, lb_m2 the row before that
    logic [PW-1:0] lb_m1 [MAX_DIM];
    logic [PW-1:0] lb_m2 [MAX_DIM];

    // pipeline registers
    logic          col_vld, col_first, col_emit, col_last;
    logic [PW-1:0] col_q [3];
    logic [PW-1:0] win [9];
    logic          v1, l1;
    logic signed [MW-1:0] prod   [CHANNELS][9];
    logic signed [MW-1:0] prod_n [CHANNELS][9];
    logic          v2, l2;
    logic [CHANNELS*ACC_WIDTH-1:0] sum_n;
    logic [ACC_WIDTH-1:0]          acc;

    // scan-position decode
    logic          advance, pos_real, scan_active, step, pos_final, pos_emit, pos_last, start_ok;
    logic          out_fire_last;
    logic [CW-1:0] grid_last, emit_off, oy, ox, last_base, last_o;
    logic [LB_AW-1:0] lb_idx;
    logic [PW-1:0] col_top_n, col_mid_n, col_bot_n;

    assign advance       = !out_valid || out_ready;
    assign grid_last     = pad_q ? dim_q : dim_q - ONE;
    assign pos_real      = (y < dim_q) && (x < dim_q);
    assign scan_active   = (state == S_RUN) && !scan_done;
    assign in_ready      = scan_active && pos_real && advance;
    assign step          = scan_active && advance && (!pos_real || in_valid);
    assign pos_final     = (y == grid_last) && (x == grid_last);
    assign emit_off      = pad_q ? ONE : TWO;
    assign oy            = y - emit_off;
    assign ox            = x - emit_off;
    // last emitted output index per axis; stride 2 rounds it down to even
    assign last_base     = pad_q ? dim_q - ONE : dim_q - THREE;
    assign last_o        = {last_base[CW-1:1], last_base[0] & ~stride_q};
    assign pos_emit      = (y >= emit_off) && (x >= emit_off) && (!stride_q || (!oy[0] && !ox[0]));
    assign pos_last      = pos_emit && (oy == last_o) && (ox == last_o);
    assign lb_idx        = (x < dim_q) ? LB_AW'(x) : '0;
    assign col_top_n     = ((y >= TWO) && (x < dim_q)) ? lb_m2[lb_idx] : '0;
    assign col_mid_n     = ((y >= ONE) && (x < dim_q)) ? lb_m1[lb_idx] : '0;
    assign col_bot_n     = pos_real ? in_data : '0;
    assign start_ok      = start && (cfg_dim >= DIM_WIDTH'(3)) && ({1'b0, cfg_dim} <= CW'(MAX_DIM));
    assign out_fire_last = out_valid && out_ready && out_last;
    assign busy          = (state == S_RUN);
    assign done          = (state == S_DONE);

    // frame FSM and raster scan counters
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            dim_q     <= '0;
            stride_q  <= 1'b0;
            pad_q     <= 1'b0;
            y         <= '0;
            x         <= '0;
            scan_done <= 1'b0;
            last_sent <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        dim_q     <= {1'b0, cfg_dim};
                        stride_q  <= cfg_stride;
                        pad_q     <= cfg_pad;
                        y         <= '0;
                        x         <= '0;
                        scan_done <= 1'b0;
                        last_sent <= 1'b0;
                        state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (step) begin
                        if (pos_final) begin
                            scan_done <= 1'b1;
                        end else if (x == grid_last) begin
                            x <= '0;
                            y <= y + ONE;
                        end else begin
                            x <= x + ONE;
                        end
                    end
                    if (out_fire_last) begin
                        last_sent <= 1'b1;
                    end
                    // the last output can precede the end of the scan (trailing non-emitting positions)
                    if (scan_done && (last_sent || out_fire_last)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // line-buffer update: shift the column down one row and store the new pixel
    always_ff @(posedge clock) begin
        if (step && pos_real) begin
            lb_m2[lb_idx] <= lb_m1[lb_idx];
            lb_m1[lb_idx] <= in_data;
        end
    end

    // capture the zero-masked incoming column with its emit/last flags
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            col_vld   <= 1'b0;
            col_first <= 1'b0;
            col_emit  <= 1'b0;
            col_last  <= 1'b0;
            for (int r = 0; r < 3; r++) col_q[r] <= '0;
        end else if (advance) begin
            col_vld <= step;
            if (step) begin
                col_first <= (x == '0);
                col_emit  <= pos_emit;
                col_last  <= pos_last;
                col_q[0]  <= col_top_n;
                col_q[1]  <= col_mid_n;
                col_q[2]  <= col_bot_n;
            end
        end
    end

    // stage 1: shift the column into the 3x3 window; column 0 clears the left columns
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            v1 <= 1'b0;
            l1 <= 1'b0;
            for (int k = 0; k < 9; k++) win[k] <= '0;
        end else if (advance) begin
            v1 <= col_vld && col_emit;
            l1 <= col_vld && col_last;
            if (col_vld) begin
                for (int r = 0; r < 3; r++) begin
                    win[3*r]   <= col_first ? '0 : win[3*r+1];
                    win[3*r+1] <= col_first ? '0 : win[3*r+2];
                    win[3*r+2] <= col_q[r];
                end
            end
        end
    end

    // per-tap products: zero-extended pixel times signed weight
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            for (int k = 0; k < 9; k++) begin
                prod_n[c][k] = $signed({{(MW-DATA_WIDTH){1'b0}}, win[k][c*DATA_WIDTH +: DATA_WIDTH]})
                             * $signed({{(MW-DATA_WIDTH){weights[(c*9+k)*DATA_WIDTH + DATA_WIDTH-1]}},
                                        weights[(c*9+k)*DATA_WIDTH +: DATA_WIDTH]});
            end
        end
    end

    // stage 2: register the products
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            v2 <= 1'b0;
            l2 <= 1'b0;
            for (int c = 0; c < CHANNELS; c++)
                for (int k = 0; k < 9; k++) prod[c][k] <= '0;
        end else if (advance) begin
            v2 <= v1;
            l2 <= l1;
            for (int c = 0; c < CHANNELS; c++)
                for (int k = 0; k < 9; k++) prod[c][k] <= prod_n[c][k];
        end
    end

    // adder tree plus bias, wrapping modulo 2^ACC_WIDTH
    always_comb begin
        sum_n = '0;
        acc   = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            acc = biases[c*ACC_WIDTH +: ACC_WIDTH];
            for (int k = 0; k < 9; k++) begin
                acc = acc + {{(ACC_WIDTH-MW){prod[c][k][MW-1]}}, prod[c][k]};
            end
            sum_n[c*ACC_WIDTH +: ACC_WIDTH] = acc;
        end
    end

    // stage 3: output register; data only changes when a new result arrives
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (advance) begin
            out_valid <= v2;
            out_last  <= l2;
            if (v2) begin
                out_data <= sum_n;
            end
        end
    end

endmodule

// File: doc/dwconv3x3_stream.md
# dwconv3x3_stream

Streaming depthwise 3x3 convolution engine for the MobileNet datapath. It accepts a raster-ordered image of CHANNELS parallel lanes per pixel and holds two internal line buffers. It produces one CHANNELS-wide result per output position, with a configurable stride (1/2) and padding mode (same/valid). Both sides use valid/ready handshakes with full backpressure. It supersedes the single-channel, stride-1, idle-polled conv block.

## Interface
Parameters:
- DATA_WIDTH, 8: pixel and weight width.
- CHANNELS, 4: parallel depthwise lanes.
- MAX_DIM, 224: largest supported square image side; sets the line-buffer depth.
- DIM_WIDTH, 8: width of cfg_dim.
- ACC_WIDTH, 32: per-channel result width. Elaboration error if < 2*DATA_WIDTH+5.

Ports:
- clock  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- start  in  1  one-cycle pulse; latches cfg_* and begins a frame.
- cfg_dim  in  DIM_WIDTH  image side N.
- cfg_stride  in  1  0 = stride 1, 1 = stride 2.
- cfg_pad  in  1  1 = same (1-pixel zero border), 0 = valid.
- weights  in  CHANNELS*9*DATA_WIDTH  signed; tap k=3*row+col, row 0 = upper row. Sampled continuously; must stay stable during a frame.
- biases  in  CHANNELS*ACC_WIDTH  signed; must stay stable during a frame.
- in_valid / in_ready  in / out  1  input handshake.
- in_data  in  CHANNELS*DATA_WIDTH  unsigned pixels, lane 0 in LSBs.
- out_valid / out_ready  out / in  1  output handshake.
- out_data  out  CHANNELS*ACC_WIDTH  signed results.
- out_last  out  1  high with the final output of a frame.
- busy  out  1  high from start accepted to done.
- done  out  1  one-cycle pulse after the last output is accepted.

## Operation
- States:
  - IDLE: waiting for start.
  - RUN: scanning.
  - DONE: asserts done for 1 cycle, then returns to IDLE.
- start is accepted only in IDLE with 3 <= cfg_dim <= MAX_DIM. Otherwise it is ignored and the block stays in IDLE.
- Scan grid with scan coordinates (y, x):
  - Pad mode: (N+1) x (N+1) positions.
  - Valid mode: N x N positions.
- Real positions (y<N and x<N) consume one input pixel. Virtual positions (y==N or x==N, pad mode only) inject zero pixels without consuming input.
- Each scanned pixel shifts into the 3x3 window. Column 0 starts a fresh window: columns left of the image read as zero.
- The window at scan (y, x) is centred on image (y-1, x-1). Rows/columns outside the image read as zero.
- Emit rule:
  - Pad mode: emit when y>=1 and x>=1.
  - Valid mode: emit when y>=2 and x>=2.
  - Stride 2 additionally requires the output row and column index to be even, counted from the first emitted position.
- Output count per side:
  - Pad: ceil(N/s).
  - Valid: floor((N-3)/s)+1.
- Arithmetic per lane:
  - out = bias + sum over the 9 taps of zero-extended pixel times signed weight.
  - Computed at full precision, then wrapped modulo 2^ACC_WIDTH.
- The frame ends when the final scan position has been processed and its output accepted. out_last marks that output. The state then goes to DONE.
- start while busy is ignored.

## Timing
- Reset values: in_ready=0, out_valid=0, out_last=0, out_data=0, busy=0, done=0, state=IDLE. Line buffers need no clearing; their reads are masked by the zero-border logic.
- Pipeline has 3 stages: window shift, multiply, adder tree + bias into the output register.
- Latency: out_valid rises 3 cycles after the clock edge that accepts the pixel completing a window.
- Global stall: advance = !out_valid || out_ready. When advance is low, every stage holds, and out_data/out_last stay stable.
- in_ready = (state==RUN) && current scan position is real && advance. It is combinational from out_ready.
- Virtual positions advance one per cycle while advance is high; in_ready stays low during them.
- in_valid low at a real position stalls the scan only. Outputs already in flight still drain.
- done pulses in the cycle after the out_last transfer. busy falls in the same cycle.
- Reset asserted mid-frame: all outputs take their reset values on the same edge. Any pending output is discarded.

## Test plan
- 4x4 image of values 1..16, valid mode, stride 1, lane 0 weights all 1, bias 0 -> exactly 4 outputs: 54, 63, 90, 99; out_last on the 4th; done one cycle later.
- Constant 100 image, N=8, pad mode, weights {1,2,1,0,0,0,-1,-2,-1} -> 64 outputs:
  - Row 0: -300 at both corners, -400 elsewhere.
  - Interior rows: 0.
  - Row 7: +300 at both corners, +400 elsewhere.
- N=5, valid mode, stride 2 -> 4 outputs, centred on (1,1), (1,3), (3,1), (3,3). N=5, pad mode, stride 2 -> 9 outputs.
- Lane 1: weights all -1, bias 7, all pixels 255, valid mode -> every lane-1 output = -2288. Lanes 0, 2 and 3 stay independent.
- Random out_ready with 10-cycle low bursts -> no dropped or duplicated outputs; out_data stable while stalled; output stream matches the unstalled reference.
- Reset pulled low mid-frame, then a fresh start with N=3, valid mode -> single correct output, out_last set, no residue from the aborted frame. start with N=2 -> ignored, busy stays 0.
